j_i2s_sched: RTL
================

// Module: j_i2s_sched
// PURPOSE
//  Stereo sample scheduler in front of the I2S unit's DAC path. Two requesters (CPU, DSP) push
//  {left,right} 16-bit pairs through a round-robin arbiter into a small FIFO. On each I2S word
//  interrupt (i2int rising edge) it pops one pair and writes it to the I2S unit with an i2s1w (left)
//  then i2s2w (right) strobe on i2s_din. It also reports FIFO level, underruns and a low-water IRQ.
// PARAMETERS
//  DEPTH_LOG2  3    FIFO depth = 2**DEPTH_LOG2 stereo pairs (legal 1..6)
//  HOLD_LAST   1    underrun policy: 1 = rewrite last popped pair, 0 = write 16'h0000 to both
// PORTS
//  clk          in   1   system clock; the only clock
//  resetl       in   1   reset, asynchronous, active-low
//  enable       in   1   scheduler enable (level)
//  flush        in   1   one-cycle pulse; empties the FIFO
//  cpu_req      in   1   CPU push request (level, held until ack)
//  cpu_l/cpu_r  in   16  CPU left/right sample
//  cpu_ack      out  1   one-cycle pulse: CPU pair accepted
//  dsp_req      in   1   DSP push request (level, held until ack)
//  dsp_l/dsp_r  in   16  DSP left/right sample
//  dsp_ack      out  1   one-cycle pulse: DSP pair accepted
//  i2int        in   1   I2S word interrupt (level from I2S unit)
//  i2s_din      out  16  data bus to the I2S unit
//  i2s1w        out  1   left DAC register write strobe
//  i2s2w        out  1   right DAC register write strobe
//  low_thresh   in   DEPTH_LOG2+1  low-water threshold
//  fifo_level   out  DEPTH_LOG2+1  pairs held, 0..2**DEPTH_LOG2
//  low_irq      out  1   registered: fifo_level <= low_thresh while enable
//  underrun_cnt out  8   saturating underrun count
// BEHAVIOUR
//  - Reset (async): FSM=IDLE, FIFO empty, last pair=0, rr pointer=CPU-preferred, all outputs 0.
//  - Arbiter: at most one push per cycle, only when FIFO not full. Both requesting -> grant the
//    requester not granted last; ack asserted in the cycle the write occurs. Full -> no ack.
//  - i2int edge: registered i2int_d; edge = i2int & ~i2int_d. Edge ignored while FSM != IDLE.
//  - FSM: IDLE --(edge & enable)--> WR_L --> WR_R --> IDLE.
//    WR_L: i2s1w=1, i2s_din=left; pop occurs here if FIFO not empty; else underrun.
//    WR_R: i2s2w=1, i2s_din=right of the same pair. Strobes are registered, 1 cycle each; i2s_din
//    is 0 in IDLE. Latency edge-cycle -> i2s1w = 1 clk; i2s2w follows immediately.
//  - Underrun (empty in WR_L): HOLD_LAST=1 writes last popped pair (0 after reset), else 0/0;
//    underrun_cnt += 1, saturates at 255; cleared only by reset.
//  - Simultaneous push and pop in one cycle: both take effect, level unchanged. Push into a full
//    FIFO that pops this cycle is NOT accepted (full is evaluated before pop).
//  - flush: FIFO empties next cycle; takes priority over push in the same cycle (no ack); an
//    in-progress WR_R still completes with the already-latched pair.
//  - enable low: no new sequences start; an in-progress L/R pair completes. Pushes still accepted.
//  - fifo_level counts 0..2**DEPTH_LOG2 inclusive; pointers wrap modulo depth.
// STRUCTURE
//  - Package j_i2s_pkg: FSM state enum (IDLE, WR_L, WR_R), SAMPLE_W=16, UNDERRUN_W=8.
//  - Sub-module j_i2s_fifo: sync FIFO, 32-bit entries {l,r}, push/pop/flush, full/empty/level.
//  - Top: arbiter, edge detect, FSM, underrun counter, low_irq register.
// TESTING
//  1 Single CPU push (1234,5678), then i2int rise -> i2s1w with 1234 at +1 clk, i2s2w 5678 at +2.
//  2 cpu_req & dsp_req held together, 4 pushes -> acks alternate CPU,DSP,CPU,DSP; level=4.
//  3 Fill DEPTH=8, 9th push held -> no ack until one pop; then ack, level stays 8.
//  4 Empty FIFO, 3 edges, HOLD_LAST=1 after pair (AAAA,BBBB) -> writes AAAA/BBBB x3, cnt=3;
//    300 underruns -> cnt=255.
//  5 resetl low during WR_L -> strobes drop immediately, level=0, cnt=0; next edge underruns.
//  6 level 2, low_thresh=2 -> low_irq=1; push -> 0; flush -> level=0, low_irq=1; enable=0 -> no
//    strobes on edges.

Source files
------------

// File: rtl/j_i2s_pkg.sv
// Shared types and constants for the I2S stereo sample scheduler.
package j_i2s_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int UNDERRUN_W = 8;
    localparam int PAIR_W     = 2 * SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_L = 2'd1,
        WR_R = 2'd2
    } sched_state_t;

    // A stereo pair is stored as {left, right}
    function automatic logic [SAMPLE_W-1:0] pair_left(input logic [PAIR_W-1:0] pair);
        return pair[PAIR_W-1:SAMPLE_W];
    endfunction

    function automatic logic [SAMPLE_W-1:0] pair_right(input logic [PAIR_W-1:0] pair);
        return pair[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/j_i2s_fifo.sv
// Synchronous FIFO of {left,right} stereo pairs with flush and an exact fill level.
module j_i2s_fifo
    import j_i2s_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  resetl,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [PAIR_W-1:0]     wdata,
    output logic [PAIR_W-1:0]     rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [PAIR_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; flush discards everything
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/j_i2s_sched.sv
// Stereo sample scheduler: round-robin CPU/DSP push arbiter, pair FIFO and an
// interrupt-driven left/right write sequencer for the I2S DAC registers.
module j_i2s_sched
    import j_i2s_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter bit HOLD_LAST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetl,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  cpu_req,
    input  logic [SAMPLE_W-1:0]   cpu_l,
    input  logic [SAMPLE_W-1:0]   cpu_r,
    output logic                  cpu_ack,
    input  logic                  dsp_req,
    input  logic [SAMPLE_W-1:0]   dsp_l,
    input  logic [SAMPLE_W-1:0]   dsp_r,
    output logic                  dsp_ack,
    input  logic                  i2int,
    output logic [SAMPLE_W-1:0]   i2s_din,
    output logic                  i2s1w,
    output logic                  i2s2w,
    input  logic [DEPTH_LOG2:0]   low_thresh,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  low_irq,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    sched_state_t          state;
    logic                  cpu_grant;
    logic                  dsp_grant;
    logic                  prefer_dsp;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PAIR_W-1:0]     fifo_rdata;
    logic [PAIR_W-1:0]     push_data;
    logic [PAIR_W-1:0]     last_pair;
    logic [PAIR_W-1:0]     underrun_pair;
    logic [SAMPLE_W-1:0]   cur_right;
    logic                  i2int_d;
    logic                  i2int_edge;
    logic                  start;
    logic                  pop;

    assign i2int_edge    = i2int & ~i2int_d;
    assign start         = (state == IDLE) & i2int_edge & enable;
    assign pop           = start & ~fifo_empty;
    assign push_data     = dsp_grant ? {dsp_l, dsp_r} : {cpu_l, cpu_r};
    assign underrun_pair = HOLD_LAST ? last_pair : '0;
    assign cpu_ack       = cpu_grant;
    assign dsp_ack       = dsp_grant;

    // Grant at most one requester per cycle; full is judged before any pop this cycle
    always_comb begin
        cpu_grant = 1'b0;
        dsp_grant = 1'b0;
        if (!flush && !fifo_full) begin
            if (cpu_req && dsp_req) begin
                if (prefer_dsp) begin
                    dsp_grant = 1'b1;
                end else begin
                    cpu_grant = 1'b1;
                end
            end else if (cpu_req) begin
                cpu_grant = 1'b1;
            end else if (dsp_req) begin
                dsp_grant = 1'b1;
            end
        end
    end

    // Round-robin pointer favours whoever was not granted most recently
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            prefer_dsp <= 1'b0;
        end else if (cpu_grant) begin
            prefer_dsp <= 1'b1;
        end else if (dsp_grant) begin
            prefer_dsp <= 1'b0;
        end
    end

    // Delayed copy of the interrupt level for rising-edge detection
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            i2int_d <= 1'b0;
        end else begin
            i2int_d <= i2int;
        end
    end

    // Write sequencer: the pair is fetched on the way into WR_L so both words come from it
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state     <= IDLE;
            i2s1w     <= 1'b0;
            i2s2w     <= 1'b0;
            i2s_din   <= '0;
            cur_right <= '0;
            last_pair <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= WR_L;
                        i2s1w <= 1'b1;
                        if (!fifo_empty) begin
                            i2s_din   <= pair_left(fifo_rdata);
                            cur_right <= pair_right(fifo_rdata);
                            last_pair <= fifo_rdata;
                        end else begin
                            i2s_din   <= pair_left(underrun_pair);
                            cur_right <= pair_right(underrun_pair);
                        end
                    end
                end
                WR_L: begin
                    state   <= WR_R;
                    i2s1w   <= 1'b0;
                    i2s2w   <= 1'b1;
                    i2s_din <= cur_right;
                end
                WR_R: begin
                    state   <= IDLE;
                    i2s2w   <= 1'b0;
                    i2s_din <= '0;
                end
                default: begin
                    state   <= IDLE;
                    i2s1w   <= 1'b0;
                    i2s2w   <= 1'b0;
                    i2s_din <= '0;
                end
            endcase
        end
    end

    // Count sequences that found the FIFO empty, sticking at the maximum
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            underrun_cnt <= '0;
        end else if (start && fifo_empty && (underrun_cnt != {UNDERRUN_W{1'b1}})) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

    // Low-water interrupt follows the level seen in the previous cycle
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            low_irq <= 1'b0;
        end else begin
            low_irq <= enable & (fifo_level <= low_thresh);
        end
    end

    j_i2s_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk    (clk),
        .resetl (resetl),
        .push   (cpu_grant | dsp_grant),
        .pop    (pop),
        .flush  (flush),
        .wdata  (push_data),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

endmodule
